dcim_stream_driver: RTL and testbench
=====================================

// Module: dcim_stream_driver
// PURPOSE
//   Host-side initiator for the 32x16 DCIM multiply macro. Buffers DEPTH weights from a host
//   stream and bursts them contiguously into the macro's init sequence (pe_ce/init_enable/data_in).
//   Then feeds activations, one slot per cycle, filling stalls with zero bubbles.
//   Collects the macro's product stream and emits one dot product per DEPTH-slot frame.
// PARAMETERS
//   DATA_WIDTH    16   weight/activation width
//   DEPTH         32   macro rows = weights per frame
//   ADDR_WIDTH    5    clog2(DEPTH)
//   PROD_WIDTH    32   macro product width
//   ACC_WIDTH     37   PROD_WIDTH+ADDR_WIDTH; frame sum cannot overflow
//   RD_LAT        3    cycles from activation on data_in to its product on data_out
//   INIT_TIMEOUT  64   max cycles to wait for init_done after the last weight
// PORTS
//   clk          in   1           clock
//   rst_n        in   1           async active-low reset
//   start        in   1           pulse; begins weight load, honoured in IDLE only
//   w_data       in   DATA_WIDTH  weight stream, row 0 first
//   w_valid      in   1           weight valid
//   w_ready      out  1           weight accepted when w_valid&w_ready
//   a_data       in   DATA_WIDTH  activation stream
//   a_valid      in   1           activation valid
//   a_ready      out  1           activation accepted when a_valid&a_ready
//   acc_data     out  ACC_WIDTH   frame dot product
//   acc_valid    out  1           1-cycle pulse, acc_data valid
//   acc_count    out  ADDR_WIDTH+1  real (non-bubble) slots in emitted frame
//   error        out  1           sticky; init timeout
//   pe_ce        out  1           macro enable
//   init_enable  out  1           macro init request
//   data_in      out  DATA_WIDTH  macro data input
//   init_done    in   1           macro reports init complete
//   valid_out    in   1           macro product valid
//   data_out     in   PROD_WIDTH  macro product
// BEHAVIOUR
//   Clock/reset: one clock clk; rst_n asynchronous, active-low.
//   Reset values: all outputs 0; state IDLE; buffer, counters, tag pipe and accumulator cleared.
//   Reset mid-operation aborts everything. The macro must be reset together with this block.
//   FSM states: IDLE -> FILL -> PROGRAM -> WAIT_INIT -> STREAM; ERROR is terminal.
//   Outputs by state:
//     IDLE: pe_ce=0, init_enable=0, data_in=0. start -> FILL.
//     FILL: w_ready=1 until DEPTH weights are buffered (wr_ptr 0..DEPTH-1), then -> PROGRAM.
//       The accept of weight DEPTH-1 moves to PROGRAM on the next edge; w_ready=0 from then on.
//     PROGRAM: exactly DEPTH cycles, pe_ce=1, data_in=buf[k] on cycle k.
//       init_enable=1 on cycle 0 only; no gaps. After cycle DEPTH-1 -> WAIT_INIT.
//     WAIT_INIT: pe_ce=1, data_in=0. -> STREAM the cycle after init_done is sampled 1.
//       If the count reaches INIT_TIMEOUT first: -> ERROR (error=1, pe_ce=0).
//     STREAM: pe_ce=1 every cycle. a_ready=1.
//       Accepted activation: data_in=a_data, tag valid=1.
//       No activation: data_in=0, tag valid=0 (bubble).
//   Frames: slot counter starts at 0 on the first STREAM cycle and wraps DEPTH-1 -> 0.
//     Slot index equals weight row; bubbles occupy slots.
//   Tags: {valid, last=(slot==DEPTH-1)} enter an RD_LAT-deep shift register.
//     The tag emerging aligns with data_out.
//   Accumulate: when tag.valid & valid_out, acc += data_out (zero-extended), acc_count++.
//   Frame end: when tag.last emerges, acc_data = final sum (incl. this slot) and acc_valid=1.
//     acc and count reset to 0 in the same cycle; the next frame starts clean.
//   Error check: tag.valid with valid_out=0 -> error=1, state ERROR.
//   All-bubble frame: still emits acc_data=0, acc_count=0.
//   start outside IDLE is ignored. w_valid outside FILL and a_valid outside STREAM are not accepted.
// TESTING
//   1. Weights row r = r+1, activations all 2 streamed back-to-back.
//      -> first acc_data = 2*sum(1..32) = 1056, acc_count=32, then every 32 cycles.
//   2. Weights all 16'hFFFF, activations all 16'hFFFF.
//      -> acc_data = 32*32'hFFFE0001 = 37'h1FFFC00020, no wrap.
//   3. Test 1 with a_valid low on slots 5 and 20.
//      -> acc_data = 1056-2*(6+21) = 1002, acc_count=30.
//   4. w_valid toggling 1/0 during FILL.
//      -> PROGRAM still emits 32 gap-free weights; init_enable high exactly 1 cycle.
//   5. init_done held 0.
//      -> error=1 after 64 WAIT_INIT cycles; pe_ce=0; start ignored.
//   6. rst_n low mid-STREAM, then start again.
//      -> all outputs 0 immediately; reload; first frame equals test 1.

Source files
------------

// File: rtl/dcim_stream_driver.sv
// -----------------------------------------------------------------------------
// dcim_stream_driver
//   Host-side initiator for the 32x16 DCIM multiply macro. Buffers one frame of
//   weights from a host stream, bursts them gap-free into the macro's init
//   sequence, then streams activations (one slot per cycle, zero bubbles when
//   the host has nothing) and folds the returned products into one dot product
//   per DEPTH-slot frame.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      pulse; begins a weight load (IDLE only)
//   w_data/w_valid/w_ready     weight stream, row 0 first
//   a_data/a_valid/a_ready     activation stream
//   acc_data/acc_valid         frame dot product, 1-cycle valid pulse
//   acc_count                  real (non-bubble) slots in the emitted frame
//   error                      sticky: init timeout or missing product
//   pe_ce/init_enable/data_in  macro control and data
//   init_done                  macro finished its init sequence
//   valid_out/data_out         macro product stream
// -----------------------------------------------------------------------------
module dcim_stream_driver #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int PROD_WIDTH   = 32,
    parameter int ACC_WIDTH    = 37,
    parameter int RD_LAT       = 3,
    parameter int INIT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [ACC_WIDTH-1:0]  acc_data,
    output logic                  acc_valid,
    output logic [ADDR_WIDTH:0]   acc_count,
    output logic                  error,
    output logic                  pe_ce,
    output logic                  init_enable,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic                  init_done,
    input  logic                  valid_out,
    input  logic [PROD_WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PROGRAM, S_WAIT_INIT, S_STREAM, S_ERROR
    } state_t;

    // Tag travelling alongside each slot until its product comes back.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    localparam int                    TW   = $clog2(INIT_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] wbuf [DEPTH];
    logic [ADDR_WIDTH-1:0] ptr;        // write pointer in FILL, read pointer in PROGRAM
    logic [TW-1:0]         wait_cnt;
    logic [ADDR_WIDTH-1:0] slot;
    tag_t                  tag_pipe [RD_LAT];
    tag_t                  tag_in, tag_out;
    logic [ACC_WIDTH-1:0]  acc, acc_sum;
    logic [ADDR_WIDTH:0]   cnt, cnt_sum;
    logic                  slot_hit, missing;

    assign tag_in = '{valid: (state == S_STREAM) && a_valid,
                      last:  (state == S_STREAM) && (slot == LAST)};
    assign tag_out  = tag_pipe[RD_LAT-1];
    assign slot_hit = tag_out.valid && valid_out;
    // A real activation whose product never showed up means the macro is out
    // of step with us; the frame sums can no longer be trusted.
    assign missing  = (state == S_STREAM) && tag_out.valid && !valid_out;
    assign acc_sum  = acc + (slot_hit ? ACC_WIDTH'(data_out) : '0);
    assign cnt_sum  = cnt + (ADDR_WIDTH + 1)'(slot_hit);
    assign error    = (state == S_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt   = state;
        pe_ce       = 1'b0;
        init_enable = 1'b0;
        data_in     = '0;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FILL;
            end
            S_FILL: begin
                w_ready = 1'b1;
                if (w_valid && ptr == LAST) state_nxt = S_PROGRAM;
            end
            S_PROGRAM: begin
                pe_ce       = 1'b1;
                data_in     = wbuf[ptr];
                init_enable = (ptr == '0);
                if (ptr == LAST) state_nxt = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                pe_ce = 1'b1;
                if (init_done)                             state_nxt = S_STREAM;
                else if (wait_cnt == TW'(INIT_TIMEOUT - 1)) state_nxt = S_ERROR;
            end
            S_STREAM: begin
                pe_ce   = 1'b1;
                a_ready = 1'b1;
                data_in = a_valid ? a_data : '0;
                if (missing) state_nxt = S_ERROR;
            end
            S_ERROR: ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the weight buffer is cleared on reset so a frame can never
            // be programmed from stale contents of a previous session.
            for (int i = 0; i < DEPTH; i++) wbuf[i] <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
            ptr       <= '0;
            wait_cnt  <= '0;
            slot      <= '0;
            acc       <= '0;
            cnt       <= '0;
            acc_data  <= '0;
            acc_count <= '0;
            acc_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of every other register.
            acc_valid <= 1'b0;

            case (state)
                S_FILL: begin
                    if (w_valid) begin
                        wbuf[ptr] <= w_data;
                        ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
                    end
                end
                S_PROGRAM: begin
                    ptr      <= (ptr == LAST) ? '0 : ptr + 1'b1;
                    wait_cnt <= '0;
                end
                S_WAIT_INIT: wait_cnt <= wait_cnt + 1'b1;
                default: ;
            endcase

            // Slot index doubles as the macro row index, so it must start at
            // zero on the first STREAM cycle.
            if (state == S_STREAM) slot <= (slot == LAST) ? '0 : slot + 1'b1;
            else                   slot <= '0;

            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            if (state == S_STREAM) begin
                if (tag_out.last) begin
                    acc_data  <= acc_sum;
                    acc_count <= cnt_sum;
                    acc_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcim_stream_driver.sv
module tb_dcim_stream_driver;

    localparam int DW = 16;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int PW = 32;
    localparam int ACCW = 37;
    localparam int MAX_SLOTS = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   w_data = '0;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [DW-1:0]   a_data = '0;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [ACCW-1:0] acc_data;
    logic            acc_valid;
    logic [AW:0]     acc_count;
    logic            error;
    logic            pe_ce;
    logic            init_enable;
    logic [DW-1:0]   data_in;
    logic            init_done;
    logic            valid_out;
    logic [PW-1:0]   data_out;

    always #5 clk = ~clk;

    dcim_stream_driver dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_count(acc_count),
        .error(error), .pe_ce(pe_ce), .init_enable(init_enable), .data_in(data_in),
        .init_done(init_done), .valid_out(valid_out), .data_out(data_out)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus plan shared by the tests.
    logic [DW-1:0] wts [DEPTH];
    bit            av  [MAX_SLOTS];
    logic [DW-1:0] ad  [MAX_SLOTS];

    // ---------------- macro model ----------------
    logic [DW-1:0] mw [DEPTH];
    int            m_idx, m_dly, m_row;
    bit            m_load, m_str, gap_err, hold_init;
    logic [PW-1:0] mp [3];
    bit            mv [3];

    assign data_out  = mp[2];
    assign valid_out = mv[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mw[i] <= '0;
            for (int i = 0; i < 3; i++) begin mp[i] <= '0; mv[i] <= 1'b0; end
            m_idx <= 0; m_dly <= 0; m_row <= 0;
            m_load <= 1'b0; m_str <= 1'b0; gap_err <= 1'b0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            if (pe_ce && init_enable) begin
                mw[0] <= data_in; m_idx <= 1; m_load <= 1'b1;
            end else if (m_load) begin
                if (!pe_ce) gap_err <= 1'b1;
                mw[m_idx] <= data_in;
                m_idx <= m_idx + 1;
                if (m_idx == DEPTH - 1) begin m_load <= 1'b0; m_dly <= 4; end
            end
            if (m_dly > 0) begin
                m_dly <= m_dly - 1;
                if (m_dly == 1 && !hold_init) init_done <= 1'b1;
            end
            if (init_done) begin m_str <= 1'b1; m_row <= 0; end
            mv[0] <= m_str && pe_ce;
            mp[0] <= (m_str && pe_ce) ? mw[m_row] * data_in : '0;
            if (m_str && pe_ce) m_row <= (m_row + 1) % DEPTH;
            mv[1] <= mv[0]; mp[1] <= mp[0];
            mv[2] <= mv[1]; mp[2] <= mp[1];
        end
    end

    // ---------------- output monitor ----------------
    logic [ACCW-1:0] got_d [$];
    logic [AW:0]     got_n [$];
    int              got_t [$];
    int              cyc = 0;
    int              ie_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_valid) begin
                got_d.push_back(acc_data);
                got_n.push_back(acc_count);
                got_t.push_back(cyc);
            end
            if (init_enable) ie_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = '0;
        a_valid = 1'b0; a_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_weights(input bit toggle);
        for (int r = 0; r < DEPTH; r++) begin
            bit taken;
            int budget;
            taken = 1'b0;
            budget = 20;
            if (toggle) begin
                w_valid = 1'b0; w_data = DW'($urandom);
                @(posedge clk); #1;
            end
            w_valid = 1'b1; w_data = wts[r];
            while (!taken && budget > 0) begin
                taken = w_ready;
                @(posedge clk); #1;
                budget--;
            end
            checks++;
            if (!taken) begin
                errors++;
                $display("FAIL weight_accept row %0d: w_ready got 0 want 1", r);
            end
        end
        w_valid = 1'b0;
        checks++;
        if (w_ready !== 1'b0) begin
            errors++;
            $display("FAIL w_ready_after_fill: got %b want 0", w_ready);
        end
    endtask

    task automatic begin_session(input bit do_rst, input bit toggle, output bit ok);
        int budget;
        if (do_rst) apply_reset();
        got_d.delete(); got_n.delete(); got_t.delete();
        ie_cnt = 0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        load_weights(toggle);
        budget = 300;
        while (!a_ready && budget > 0) begin @(posedge clk); #1; budget--; end
        ok = a_ready;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reach_stream: a_ready got 0 want 1 within 300 cycles");
        end
    endtask

    task automatic stream_slots(input int n);
        for (int s = 0; s < n; s++) begin
            a_valid = av[s]; a_data = ad[s];
            @(posedge clk); #1;
        end
        a_valid = 1'b0; a_data = '0;
    endtask

    // Reference: each frame is the plain dot product of the weight row vector
    // with that frame's activations, bubbles contributing nothing.
    task automatic check_frames(input int nfr, input string name, input bit chk_period);
        int budget;
        int bad;
        budget = nfr * DEPTH + 100;
        while (got_d.size() < nfr && budget > 0) begin @(posedge clk); #1; budget--; end
        checks++;
        if (got_d.size() < nfr) begin
            errors++;
            $display("FAIL %s frames: got %0d want %0d", name, got_d.size(), nfr);
        end
        for (int f = 0; f < nfr && f < got_d.size(); f++) begin
            logic [ACCW-1:0] exp_d;
            int exp_n;
            exp_d = '0; exp_n = 0;
            for (int s = 0; s < DEPTH; s++) begin
                if (av[f*DEPTH + s]) begin
                    exp_d += ACCW'(wts[s]) * ACCW'(ad[f*DEPTH + s]);
                    exp_n++;
                end
            end
            checks++;
            if (got_d[f] !== exp_d) begin
                errors++;
                $display("FAIL %s frame %0d acc_data: got %0h want %0h", name, f, got_d[f], exp_d);
            end
            checks++;
            if (got_n[f] !== (AW+1)'(exp_n)) begin
                errors++;
                $display("FAIL %s frame %0d acc_count: got %0d want %0d", name, f, got_n[f], exp_n);
            end
            if (chk_period && f > 0) begin
                checks++;
                if (got_t[f] - got_t[f-1] != DEPTH) begin
                    errors++;
                    $display("FAIL %s frame %0d period: got %0d want %0d", name, f,
                             got_t[f] - got_t[f-1], DEPTH);
                end
            end
        end
        bad = 0;
        for (int r = 0; r < DEPTH; r++) if (mw[r] !== wts[r]) bad++;
        checks++;
        if (bad != 0 || gap_err) begin
            errors++;
            $display("FAIL %s program: bad rows got %0d gap %b want 0 0", name, bad, gap_err);
        end
        checks++;
        if (ie_cnt != 1) begin
            errors++;
            $display("FAIL %s init_enable cycles: got %0d want 1", name, ie_cnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({pe_ce, init_enable, w_ready, a_ready, acc_valid, error} !== 6'b0) begin
            errors++;
            $display("FAIL %s ctrl {pe_ce,ie,w_rdy,a_rdy,acc_v,err}: got %b want 000000", name,
                     {pe_ce, init_enable, w_ready, a_ready, acc_valid, error});
        end
        checks++;
        if (data_in !== '0 || acc_data !== '0 || acc_count !== '0) begin
            errors++;
            $display("FAIL %s data: data_in %0h acc_data %0h acc_count %0d want 0 0 0", name,
                     data_in, acc_data, acc_count);
        end
    endtask

    task automatic plan_ramp(input int n);
        for (int r = 0; r < DEPTH; r++) wts[r] = DW'(r + 1);
        for (int s = 0; s < n; s++) begin av[s] = 1'b1; ad[s] = 16'd2; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_all_zero("reset_low");
        apply_reset();
        check_all_zero("reset_idle");
    endtask

    task automatic test_ramp();
        bit ok;
        plan_ramp(96);
        begin_session(1'b1, 1'b0, ok);
        if (ok) begin
            stream_slots(96);
            check_frames(3, "ramp", 1'b1);
            if (got_d.size() > 0) begin
                checks++;
                if (got_d[0] !== 37'd1056 || got_n[0] !== 6'd32) begin
                    errors++;
                    $display("FAIL ramp_const: got %0d/%0d want 1056/32", got_d[0], got_n[0]);
                end
            end
        end
    endtask

    task automatic test_max();
        bit ok;
        for (int r = 0; r < DEPTH; r++) wts[r] = 16'hFFFF;
        for (int s = 0; s < 64; s++) begin av[s] = 1'b1; ad[s] = 16'hFFFF; end
        begin_session(1'b1, 1'b0, ok);
        if (ok) begin
            stream_slots(64);
            check_frames(2, "max", 1'b0);
            if (got_d.size() > 0) begin
                checks++;
                if (got_d[0] !== 37'h1FFFC00020) begin
                    errors++;
                    $display("FAIL max_const: got %0h want 1fffc00020", got_d[0]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        bit ok;
        plan_ramp(64);
        for (int s = 0; s < 64; s++) if (s % DEPTH == 5 || s % DEPTH == 20) av[s] = 1'b0;
        begin_session(1'b1, 1'b0, ok);
        if (ok) begin
            stream_slots(64);
            check_frames(2, "bubbles", 1'b0);
            if (got_d.size() > 0) begin
                checks++;
                if (got_d[0] !== 37'd1002 || got_n[0] !== 6'd30) begin
                    errors++;
                    $display("FAIL bubbles_const: got %0d/%0d want 1002/30", got_d[0], got_n[0]);
                end
            end
        end
    endtask

    task automatic test_fill_toggle();
        bit ok;
        for (int r = 0; r < DEPTH; r++) wts[r] = DW'($urandom);
        for (int s = 0; s < 64; s++) begin av[s] = 1'b1; ad[s] = DW'($urandom); end
        begin_session(1'b1, 1'b1, ok);
        if (ok) begin
            stream_slots(64);
            check_frames(2, "fill_toggle", 1'b0);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int r = 0; r < DEPTH; r++) wts[r] = DW'($urandom);
        for (int s = 0; s < 128; s++) begin
            av[s] = ($urandom_range(0, 9) < 7) && (s / DEPTH != 2);
            ad[s] = DW'($urandom);
        end
        begin_session(1'b1, 1'b0, ok);
        if (ok) begin
            stream_slots(128);
            check_frames(4, "random", 1'b1);
            if (got_d.size() > 2) begin
                checks++;
                if (got_d[2] !== '0 || got_n[2] !== '0) begin
                    errors++;
                    $display("FAIL all_bubble_frame: got %0h/%0d want 0/0", got_d[2], got_n[2]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int pcnt;
        int n;
        for (int r = 0; r < DEPTH; r++) wts[r] = DW'($urandom);
        hold_init = 1'b1;
        apply_reset();
        ie_cnt = 0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        load_weights(1'b0);
        pcnt = 0; n = 0;
        while (!error && n < 400) begin
            if (pe_ce) pcnt++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (error !== 1'b1 || pcnt != 96) begin
            errors++;
            $display("FAIL timeout: error %b pe_ce cycles %0d want 1 96", error, pcnt);
        end
        checks++;
        if (pe_ce !== 1'b0 || ie_cnt != 1) begin
            errors++;
            $display("FAIL timeout_outputs: pe_ce %b ie %0d want 0 1", pe_ce, ie_cnt);
        end
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        w_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || w_ready !== 1'b0 || pe_ce !== 1'b0) begin
            errors++;
            $display("FAIL error_sticky: error %b w_ready %b pe_ce %b want 1 0 0", error, w_ready, pe_ce);
        end
        w_valid = 1'b0;
        hold_init = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        plan_ramp(96);
        begin_session(1'b1, 1'b0, ok);
        if (ok) begin
            for (int s = 0; s < 40; s++) begin
                a_valid = 1'b1; a_data = 16'd2;
                @(posedge clk); #1;
            end
            #2 rst_n = 1'b0;
            #1;
            check_all_zero("mid_stream_reset");
            a_valid = 1'b0; a_data = '0;
            @(posedge clk); #1 rst_n = 1'b1;
            @(posedge clk); #1;
            begin_session(1'b0, 1'b0, ok);
            if (ok) begin
                stream_slots(64);
                check_frames(2, "after_reset", 1'b0);
                if (got_d.size() > 0) begin
                    checks++;
                    if (got_d[0] !== 37'd1056 || got_n[0] !== 6'd32) begin
                        errors++;
                        $display("FAIL after_reset_const: got %0d/%0d want 1056/32", got_d[0], got_n[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        hold_init = 1'b0;
        test_reset();
        test_ramp();
        test_max();
        test_bubbles();
        test_fill_toggle();
        test_random();
        test_timeout();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
